// File: rtl/filter_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// filter_frame_sequencer_if
// Bundles every bus of the frame sequencer: the frame request/status pair,
// the three-port input RAM read bus, the 3x3 filter core stream and the
// output RAM write bus.
//   slave  : the sequencer side (drives read/write/core strobes and status)
//   master : the surrounding system (issues start, returns RAM and core data)
// ---------------------------------------------------------------------------
interface filter_frame_sequencer_if #(
    parameter int ADDR_W = 19
);
    // frame control
    logic              start;
    logic [7:0]        filter_sel;
    logic              busy;
    logic              done;
    // input RAM read bus
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [ADDR_W-1:0] rd_addr3;
    logic [7:0]        rd_data1;
    logic [7:0]        rd_data2;
    logic [7:0]        rd_data3;
    // filter core stream
    logic              core_start;
    logic [7:0]        core_filter;
    logic [7:0]        core_pixel1;
    logic [7:0]        core_pixel2;
    logic [7:0]        core_pixel3;
    logic [7:0]        core_pixel;
    // output RAM write bus
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport slave (
        input  start, filter_sel,
        input  rd_data1, rd_data2, rd_data3,
        input  core_pixel,
        output busy, done,
        output rd_en, rd_addr1, rd_addr2, rd_addr3,
        output core_start, core_filter, core_pixel1, core_pixel2, core_pixel3,
        output wr_en, wr_addr, wr_data
    );

    modport master (
        output start, filter_sel,
        output rd_data1, rd_data2, rd_data3,
        output core_pixel,
        input  busy, done,
        input  rd_en, rd_addr1, rd_addr2, rd_addr3,
        input  core_start, core_filter, core_pixel1, core_pixel2, core_pixel3,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/filter_frame_sequencer.sv
// ---------------------------------------------------------------------------
// filter_frame_sequencer
// Frame-level controller for the 3x3 window filter core. On start it walks
// the interior output rows of an IMG_W x IMG_H image, reading rows r-1, r and
// r+1 one column per clock from a three-port synchronous RAM, streams them
// into the core, and writes each core result to the output RAM at the
// centre-pixel address. A tag pipeline travelling alongside the core carries
// the write address and a valid bit so the core needs no address of its own.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : filter_frame_sequencer_if.slave
//            start/filter_sel in, busy/done out
//            rd_en/rd_addr1..3 out, rd_data1..3 in (1 clk read latency)
//            core_start/core_filter/core_pixel1..3 out, core_pixel in
//            wr_en/wr_addr/wr_data out
//
// State table:
//   S_IDLE   | waiting for start; outputs quiet
//   S_STREAM | one column read per clock across all interior rows
//   S_DRAIN  | reads finished; waiting for the last tag to leave the pipe
//   S_FINISH | one-clock done pulse, busy drops, back to idle
// ---------------------------------------------------------------------------
module filter_frame_sequencer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int ADDR_W     = 19,
    parameter int FILTER_LAT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    filter_frame_sequencer_if.slave bus
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int TAG_D = 1 + FILTER_LAT;

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W2_A     = ADDR_W'(2 * IMG_W);
    // every tag stage except the one leaving this clock
    localparam logic [TAG_D-1:0]  TAG_MASK_IN = {TAG_D{1'b1}} >> 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_row_base;    // (r-1)*IMG_W
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr1;
    logic [ADDR_W-1:0] r_rd_addr2;
    logic [ADDR_W-1:0] r_rd_addr3;
    logic              r_core_start;
    logic [7:0]        r_core_filter;

    logic [TAG_D-1:0]  r_tag_vld;
    logic [ADDR_W-1:0] r_tag_addr [TAG_D];

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic              w_last_col;
    logic              w_last_row;
    logic [COL_W-1:0]  w_next_col;
    logic [ADDR_W-1:0] w_next_base;
    logic [ADDR_W-1:0] w_next_addr1;
    logic              w_push_vld;
    logic [ADDR_W-1:0] w_push_addr;
    logic              w_tags_in_flight;

    assign w_last_col   = (r_col == LAST_COL);
    assign w_last_row   = (r_row == LAST_ROW);
    assign w_next_col   = w_last_col ? '0 : r_col + COL_W'(1);
    assign w_next_base  = w_last_col ? r_row_base + W_A : r_row_base;
    assign w_next_addr1 = w_next_base + ADDR_W'(w_next_col);

    // The window ending at column c is centred on c-1 of row r. Columns 0
    // and 1 still mix in the tail of the previous row, so they never write.
    assign w_push_vld  = r_rd_en && (r_col >= COL_W'(2));
    assign w_push_addr = r_rd_addr2 - ADDR_W'(1);

    assign w_tags_in_flight = |(r_tag_vld & TAG_MASK_IN);

    // ------------------------------------------------------------------
    // Control FSM: read address generation, status and core enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_row_base    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_addr1    <= '0;
            r_rd_addr2    <= '0;
            r_rd_addr3    <= '0;
            r_core_start  <= 1'b0;
            r_core_filter <= '0;
        end else begin
            r_done       <= 1'b0;
            // read data is valid exactly one clock after the strobe
            r_core_start <= r_rd_en;

            case (r_state)
                S_IDLE: begin
                    // a start seen while done is still high is dropped
                    if (bus.start && !r_done) begin
                        r_core_filter <= bus.filter_sel;
                        r_busy        <= 1'b1;
                        r_row         <= ROW_W'(1);
                        r_col         <= '0;
                        r_row_base    <= '0;
                        r_rd_en       <= 1'b1;
                        r_rd_addr1    <= '0;
                        r_rd_addr2    <= W_A;
                        r_rd_addr3    <= W2_A;
                        r_state       <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (w_last_col && w_last_row) begin
                        r_rd_en <= 1'b0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_col      <= w_next_col;
                        r_row_base <= w_next_base;
                        if (w_last_col) begin
                            r_row <= r_row + ROW_W'(1);
                        end
                        r_rd_addr1 <= w_next_addr1;
                        r_rd_addr2 <= w_next_addr1 + W_A;
                        r_rd_addr3 <= w_next_addr1 + W2_A;
                    end
                end

                S_DRAIN: begin
                    // the final tag leaves on this edge and becomes the last write
                    if (!w_tags_in_flight) begin
                        r_state <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: one stage for the RAM read, FILTER_LAT for the core.
    // Idle and drain cycles shift in empty tags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i < TAG_D; i++) begin
                r_tag_addr[i] <= '0;
            end
        end else begin
            r_tag_vld[0]  <= w_push_vld;
            r_tag_addr[0] <= w_push_addr;
            for (int i = 1; i < TAG_D; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write stage: core_pixel is aligned with the tag leaving the pipe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= r_tag_vld[TAG_D-1];
            if (r_tag_vld[TAG_D-1]) begin
                r_wr_addr <= r_tag_addr[TAG_D-1];
                r_wr_data <= bus.core_pixel;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.rd_en       = r_rd_en;
    assign bus.rd_addr1    = r_rd_addr1;
    assign bus.rd_addr2    = r_rd_addr2;
    assign bus.rd_addr3    = r_rd_addr3;
    assign bus.core_start  = r_core_start;
    assign bus.core_filter = r_core_filter;
    assign bus.core_pixel1 = bus.rd_data1;
    assign bus.core_pixel2 = bus.rd_data2;
    assign bus.core_pixel3 = bus.rd_data3;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;

endmodule

// File: doc/filter_frame_sequencer.md
Name: filter_frame_sequencer

Overview:
- Frame-level controller for the 3x3 window filter core (Sobel / median).
- On `start`, walks an IMG_W x IMG_H 8-bit image stored in three-port synchronous read RAM. For each interior output row it fetches rows r-1, r and r+1 column by column, streams them into the core as `core_pixel1..3`, and tags each fed column.
- Writes each core result to the output image RAM at the correct centre-pixel address, then signals `done`.
- Replaces the core's free-running `Pixel_address` with a controller-owned address pipeline.

Parameters:
- IMG_W, 640, image width in pixels (>=3)
- IMG_H, 480, image height in pixels (>=3)
- ADDR_W, 19, pixel address width (IMG_W*IMG_H <= 2^ADDR_W)
- FILTER_LAT, 4, clocks from the edge where the core samples a column to the edge where `core_pixel` holds the result for the window ending at that column

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to process one frame; ignored unless IDLE
- filter_sel  in  8  0 = Sobel, 1 = median; latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  read strobe to the input RAM (all three ports)
- rd_addr1  out  ADDR_W  row r-1 address
- rd_addr2  out  ADDR_W  row r address
- rd_addr3  out  ADDR_W  row r+1 address
- rd_data1  in  8  port 1 data, valid 1 clk after rd_en
- rd_data2  in  8  port 2 data
- rd_data3  in  8  port 3 data
- core_start  out  1  core enable; rd_en delayed 1 clk
- core_filter  out  8  latched filter_sel
- core_pixel1  out  8  = rd_data1 (wire)
- core_pixel2  out  8  = rd_data2 (wire)
- core_pixel3  out  8  = rd_data3 (wire)
- core_pixel  in  8  core result pixel
- wr_en  out  1  output RAM write strobe
- wr_addr  out  ADDR_W  output pixel address
- wr_data  out  8  output pixel value

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; row/column counters cleared; tag pipeline cleared; latched filter 0.
  - Reset mid-frame aborts immediately. No `done` pulse; no further writes.
- States: IDLE, STREAM, DRAIN, FINISH.
- IDLE, start=1 at edge T:
  - latch filter_sel; r=1, c=0; busy=1; state=STREAM from T+1.
- STREAM, one column per clk:
  - rd_en=1
  - rd_addr1=(r-1)*IMG_W+c
  - rd_addr2=r*IMG_W+c
  - rd_addr3=(r+1)*IMG_W+c
  - Addresses are computed as a running row base plus c, not with a multiplier; the row base advances by IMG_W at each row wrap.
- Column and row counting:
  - c increments; at c=IMG_W-1, c wraps to 0 and r increments.
  - After issuing c=IMG_W-1 of r=IMG_H-2, go to DRAIN with rd_en=0.
  - Total read cycles: (IMG_H-2)*IMG_W.
- Tag pipeline, depth 1+FILTER_LAT:
  - Each issued column pushes {valid=(c>=2), addr=r*IMG_W+c-1}.
  - The window ending at column c is centred at c-1.
  - Columns 0 and 1 of every row carry valid=0, because the core window still contains the previous row's columns.
  - Non-read cycles push valid=0.
- Write stage:
  - When a valid tag exits, the registered outputs take wr_en=1, wr_addr=tag.addr, wr_data=core_pixel at that edge.
  - Otherwise wr_en=0; wr_addr and wr_data hold.
- Border pixels (row 0, row IMG_H-1, column 0, column IMG_W-1) are never written.
- Writes per frame: exactly (IMG_W-2)*(IMG_H-2), with strictly increasing addresses.
- DRAIN: hold until the tag pipeline is empty, i.e. the last write is issued; then go to FINISH.
- FINISH: done=1 for one clk; busy=0 on the same edge; state returns to IDLE.
- start during STREAM, DRAIN or FINISH: ignored, no queueing.
- filter_sel changes mid-frame: no effect; core_filter holds the latched value.
- start in the same cycle done is high: ignored. A new frame may start on the cycle after done.
- core_start is high for exactly the cycles in which rd_data is valid.

Test Plan:
- Reset: assert rst_n=0 with IMG_W=5, IMG_H=4 -> all outputs 0, state IDLE, no writes for 20 clks with start=0.
- Basic frame: IMG_W=5, IMG_H=4, FILTER_LAT=4, start at edge 0 ->
  - rd_en high edges 1..10; rd_addr2 = 5..9 then 10..14.
  - Exactly 6 writes, to addresses 6,7,8,11,12,13.
  - done pulses once, one clk after the last write; busy low afterwards.
- Data path: the core model returns the centre pixel, and the input RAM holds value = address mod 256 -> wr_data equals wr_addr for every write.
- Restart/ignore: pulse start at edge 3 of the frame -> no effect, same 6 writes. Pulse start one clk after done -> second identical frame.
- Filter latch: filter_sel=1 at start, changed to 0 at edge 4 -> core_filter stays 1 for the whole frame.
- Abort: rst_n=0 after the 3rd write -> wr_en, busy and done drop to 0 asynchronously. After release, a new start yields the full 6 writes.
